// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: default sizing, the broadcast packet
// layout and the flattening offsets used to map FU categories onto requester
// indices (ALU, MULT, BRANCH, MEM order).
package cdb_arbiter_pkg;

    localparam int unsigned NUM_CDB_PORTS = 2;
    localparam int unsigned CDB_NUM_REQ   = 8;
    localparam int unsigned CDB_TAG_W     = 6;
    localparam int unsigned CDB_DATA_W    = 32;
    localparam int unsigned CDB_SRC_W     = $clog2(CDB_NUM_REQ);

    // Requester index of the first FU in each category.
    localparam int unsigned FU_ALU_BASE    = 0;
    localparam int unsigned FU_MULT_BASE   = 3;
    localparam int unsigned FU_BRANCH_BASE = 5;
    localparam int unsigned FU_MEM_BASE    = 6;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic [CDB_SRC_W-1:0]  src;
    } cdb_packet_t;

endpackage

// File: rtl/rr_multi_select.sv
// Combinational rotating-priority selector granting up to NUM_CDB requesters.
// Ports:
//   req_i       - request vector
//   start_i     - index where the scan begins (wraps modulo NUM_REQ)
//   gnt_valid_o - port k received a grant
//   gnt_oh_o    - one-hot requester grant per port (zero when unused)
//   gnt_idx_o   - requester index per port (zero when unused)
//   last_idx_o  - index of the last requester granted in scan order
module rr_multi_select #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned NUM_CDB = 2,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [IDX_W-1:0]                  start_i,
    output logic [NUM_CDB-1:0]                gnt_valid_o,
    output logic [NUM_CDB-1:0][NUM_REQ-1:0]   gnt_oh_o,
    output logic [NUM_CDB-1:0][IDX_W-1:0]     gnt_idx_o,
    output logic [IDX_W-1:0]                  last_idx_o
);

    always_comb begin
        logic [IDX_W:0]     sum;
        logic [IDX_W-1:0]   idx;
        logic [NUM_REQ-1:0] taken;
        sum         = '0;
        idx         = '0;
        taken       = '0;
        gnt_valid_o = '0;
        gnt_oh_o    = '0;
        gnt_idx_o   = '0;
        last_idx_o  = '0;
        // Each port takes the first not-yet-taken requester in scan order, so
        // port order matches scan order and the final assignment is the last grant.
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                sum = {1'b0, start_i} + (IDX_W+1)'(off);
                if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                    sum = sum - (IDX_W+1)'(NUM_REQ);
                end
                idx = sum[IDX_W-1:0];
                if (!gnt_valid_o[k] && req_i[idx] && !taken[idx]) begin
                    gnt_valid_o[k]   = 1'b1;
                    gnt_oh_o[k][idx] = 1'b1;
                    gnt_idx_o[k]     = idx;
                    taken[idx]       = 1'b1;
                    last_idx_o       = idx;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each FU has a one-entry holding register, and held
// results compete under rotating priority for NUM_CDB broadcast ports.
// Ports:
//   clock_i, reset_n_i   - clock (rising edge), asynchronous active-low reset
//   flush_i              - synchronous squash of all held results
//   fu_done_valid_i/tag_i/data_i - completed results from the FUs
//   fu_avail_o           - FU may present a result next cycle
//   cdb_valid_o/tag_o/data_o/src_o - broadcast ports (zero when unused)
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = CDB_NUM_REQ,
    parameter int unsigned NUM_CDB = NUM_CDB_PORTS,
    parameter int unsigned TAG_W   = CDB_TAG_W,
    parameter int unsigned DATA_W  = CDB_DATA_W,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clock_i,
    input  logic                              reset_n_i,
    input  logic                              flush_i,
    input  logic [NUM_REQ-1:0]                fu_done_valid_i,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]     fu_done_tag_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    fu_done_data_i,
    output logic [NUM_REQ-1:0]                fu_avail_o,
    output logic [NUM_CDB-1:0]                cdb_valid_o,
    output logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag_o,
    output logic [NUM_CDB-1:0][DATA_W-1:0]    cdb_data_o,
    output logic [NUM_CDB-1:0][IDX_W-1:0]     cdb_src_o
);

    logic [NUM_REQ-1:0]               held_valid_q, held_valid_d;
    logic [NUM_REQ-1:0][TAG_W-1:0]    held_tag_q, held_tag_d;
    logic [NUM_REQ-1:0][DATA_W-1:0]   held_data_q, held_data_d;
    logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;

    logic [NUM_CDB-1:0]               gnt_valid;
    logic [NUM_CDB-1:0][NUM_REQ-1:0]  gnt_oh;
    logic [NUM_CDB-1:0][IDX_W-1:0]    gnt_idx;
    logic [IDX_W-1:0]                 last_idx;
    logic [NUM_REQ-1:0]               granted;

    rr_multi_select #(
        .NUM_REQ (NUM_REQ),
        .NUM_CDB (NUM_CDB)
    ) u_select (
        .req_i       (held_valid_q),
        .start_i     (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_oh_o    (gnt_oh),
        .gnt_idx_o   (gnt_idx),
        .last_idx_o  (last_idx)
    );

    // One-hot AND-OR mux from the holding registers onto each port.
    always_comb begin
        granted    = '0;
        cdb_tag_o  = '0;
        cdb_data_o = '0;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt_oh[k][i]) begin
                    cdb_tag_o[k]  = cdb_tag_o[k] | held_tag_q[i];
                    cdb_data_o[k] = cdb_data_o[k] | held_data_q[i];
                    granted[i]    = 1'b1;
                end
            end
        end
    end

    assign cdb_valid_o = gnt_valid;
    assign cdb_src_o   = gnt_idx;
    assign fu_avail_o  = ~held_valid_q | granted;

    always_comb begin
        held_valid_d = held_valid_q;
        held_tag_d   = held_tag_q;
        held_data_d  = held_data_q;
        rr_ptr_d     = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // A granted entry may be refilled in the same cycle it drains.
            if (fu_done_valid_i[i] && fu_avail_o[i]) begin
                held_valid_d[i] = 1'b1;
                held_tag_d[i]   = fu_done_tag_i[i];
                held_data_d[i]  = fu_done_data_i[i];
            end else if (granted[i]) begin
                held_valid_d[i] = 1'b0;
            end
        end
        if (gnt_valid[0]) begin
            rr_ptr_d = (last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : last_idx + IDX_W'(1);
        end
        if (flush_i) begin
            held_valid_d = '0;
            rr_ptr_d     = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            held_valid_q <= '0;
            held_tag_q   <= '0;
            held_data_q  <= '0;
            rr_ptr_q     <= '0;
        end else begin
            held_valid_q <= held_valid_d;
            held_tag_q   <= held_tag_d;
            held_data_q  <= held_data_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_REQ=4, NUM_CDB=2): directed
// scenarios followed by randomized legal traffic, all compared against a
// behavioural model of held results and rotating priority.
module tb_cdb_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned NC = 2;
    localparam int unsigned TW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic                    clock = 1'b0;
    logic                    reset_n;
    logic                    flush;
    logic [NR-1:0]           fu_done_valid;
    logic [NR-1:0][TW-1:0]   fu_done_tag;
    logic [NR-1:0][DW-1:0]   fu_done_data;
    logic [NR-1:0]           fu_avail;
    logic [NC-1:0]           cdb_valid;
    logic [NC-1:0][TW-1:0]   cdb_tag;
    logic [NC-1:0][DW-1:0]   cdb_data;
    logic [NC-1:0][IW-1:0]   cdb_src;

    cdb_arbiter #(
        .NUM_REQ (NR),
        .NUM_CDB (NC),
        .TAG_W   (TW),
        .DATA_W  (DW)
    ) dut (
        .clock_i         (clock),
        .reset_n_i       (reset_n),
        .flush_i         (flush),
        .fu_done_valid_i (fu_done_valid),
        .fu_done_tag_i   (fu_done_tag),
        .fu_done_data_i  (fu_done_data),
        .fu_avail_o      (fu_avail),
        .cdb_valid_o     (cdb_valid),
        .cdb_tag_o       (cdb_tag),
        .cdb_data_o      (cdb_data),
        .cdb_src_o       (cdb_src)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    bit          m_vld  [NR];
    logic [TW-1:0] m_tag  [NR];
    logic [DW-1:0] m_data [NR];
    int          m_rr;

    // Expected grants derived from the model state.
    bit e_v   [NC];
    int e_src [NC];
    bit e_gnt [NR];
    int e_last;

    // Stimulus for the next edge.
    logic [NR-1:0] s_dv;
    bit            s_fl;
    logic [TW-1:0] s_tag  [NR];
    logic [DW-1:0] s_data [NR];

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_vld[i] = 0;
        m_rr = 0;
    endtask

    task automatic model_grant();
        int k;
        k = 0;
        e_last = 0;
        for (int p = 0; p < NC; p++) begin e_v[p] = 0; e_src[p] = 0; end
        for (int i = 0; i < NR; i++) e_gnt[i] = 0;
        for (int off = 0; off < NR; off++) begin
            int i;
            i = (m_rr + off) % NR;
            if (m_vld[i] && k < NC) begin
                e_v[k] = 1; e_src[k] = i; e_gnt[i] = 1; e_last = i; k++;
            end
        end
    endtask

    function automatic logic [NR-1:0] model_avail();
        logic [NR-1:0] a;
        for (int i = 0; i < NR; i++) a[i] = !m_vld[i] || e_gnt[i];
        return a;
    endfunction

    task automatic model_advance();
        logic [NR-1:0] av;
        av = model_avail();
        if (s_fl) begin
            model_reset();
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (s_dv[i] && av[i]) begin
                    m_vld[i] = 1; m_tag[i] = s_tag[i]; m_data[i] = s_data[i];
                end else if (e_gnt[i]) begin
                    m_vld[i] = 0;
                end
            end
            if (e_v[0]) m_rr = (e_last + 1) % NR;
        end
    endtask

    task automatic check_all(input string ph);
        model_grant();
        for (int p = 0; p < NC; p++) begin
            check($sformatf("%s_valid%0d", ph, p), 64'(cdb_valid[p]), 64'(e_v[p]));
            check($sformatf("%s_tag%0d", ph, p), 64'(cdb_tag[p]),
                  e_v[p] ? 64'(m_tag[e_src[p]]) : 64'd0);
            check($sformatf("%s_data%0d", ph, p), 64'(cdb_data[p]),
                  e_v[p] ? 64'(m_data[e_src[p]]) : 64'd0);
            check($sformatf("%s_src%0d", ph, p), 64'(cdb_src[p]), 64'(e_src[p]));
        end
        check($sformatf("%s_avail", ph), 64'(fu_avail), 64'(model_avail()));
    endtask

    task automatic run_cycle(input string ph);
        check_all(ph);
        fu_done_valid = s_dv;
        flush         = s_fl;
        for (int i = 0; i < NR; i++) begin
            fu_done_tag[i]  = s_tag[i];
            fu_done_data[i] = s_data[i];
        end
        @(posedge clock);
        #1;
        model_advance();
    endtask

    task automatic set_stim(input logic [NR-1:0] dv, input bit fl, input int base);
        s_dv = dv;
        s_fl = fl;
        for (int i = 0; i < NR; i++) begin
            s_tag[i]  = TW'(base + i);
            s_data[i] = DW'(32'hA000_0000 + 32'(base * 16 + i));
        end
    endtask

    // Asynchronous reset mid-cycle, with an immediate check before any edge.
    task automatic async_reset(input string ph);
        fu_done_valid = '0;
        flush = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(ph);
        check({ph, "_async_valid"}, 64'(cdb_valid), 64'd0);
        check({ph, "_async_avail"}, 64'(fu_avail), 64'hF);
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Legal stimulus never drives a result into an unavailable FU.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            check("protocol", 64'(fu_done_valid & ~fu_avail), 64'd0);
        end
    end

    initial begin
        reset_n       = 1'b0;
        flush         = 1'b0;
        fu_done_valid = '0;
        fu_done_tag   = '0;
        fu_done_data  = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Single result from FU2.
        set_stim(4'b0100, 0, 0);
        s_tag[2] = 6'h05; s_data[2] = 32'hDEAD;
        run_cycle("single_in");
        check("single_valid", 64'(cdb_valid), 64'b01);
        check("single_tag", 64'(cdb_tag[0]), 64'h05);
        check("single_src", 64'(cdb_src[0]), 64'd2);
        check("single_avail", 64'(fu_avail), 64'hF);

        // FU0 and FU3 arrive while rr_ptr becomes 3: wraparound order.
        set_stim(4'b1001, 0, 8);
        run_cycle("wrap_in");
        check("wrap_src0", 64'(cdb_src[0]), 64'd3);
        check("wrap_src1", 64'(cdb_src[1]), 64'd0);
        check("wrap_valid", 64'(cdb_valid), 64'b11);

        // rr_ptr should now be 1: held {0,2,3} grants FU2 then FU3.
        set_stim(4'b1101, 0, 16);
        run_cycle("rr1_in");
        check("rr1_src0", 64'(cdb_src[0]), 64'd2);
        check("rr1_src1", 64'(cdb_src[1]), 64'd3);

        // Fill all four, then flush with a new FU0 result in the flush cycle.
        set_stim(4'b1110, 0, 24);
        run_cycle("fill_in");
        set_stim(4'b0001, 1, 32);
        run_cycle("flush_in");
        check("flush_valid", 64'(cdb_valid), 64'd0);
        check("flush_avail", 64'(fu_avail), 64'hF);

        // Oversubscription from rr_ptr = 0.
        set_stim(4'b1111, 0, 40);
        run_cycle("over_in");
        check("over1_src0", 64'(cdb_src[0]), 64'd0);
        check("over1_src1", 64'(cdb_src[1]), 64'd1);
        check("over1_avail", 64'(fu_avail), 64'b0011);
        set_stim(4'b0000, 0, 48);
        run_cycle("over1");
        check("over2_src0", 64'(cdb_src[0]), 64'd2);
        check("over2_src1", 64'(cdb_src[1]), 64'd3);
        run_cycle("over2");
        check("over3_valid", 64'(cdb_valid), 64'd0);

        // Drain-and-refill on FU1.
        set_stim(4'b0010, 0, 56);
        s_tag[1] = 6'h03;
        run_cycle("refill_a");
        set_stim(4'b0010, 0, 56);
        s_tag[1] = 6'h09;
        run_cycle("refill_b");
        check("refill_valid", 64'(cdb_valid), 64'b01);
        check("refill_tag", 64'(cdb_tag[0]), 64'h09);
        check("refill_src", 64'(cdb_src[0]), 64'd1);

        // Reset with held = 1011.
        set_stim(4'b0000, 0, 0);
        run_cycle("pre_rst_drain");
        set_stim(4'b1011, 0, 60);
        run_cycle("pre_rst_fill");
        check("pre_rst_valid", 64'(cdb_valid), 64'b11);
        async_reset("midrst");

        // Randomized legal traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [NR-1:0] av;
            if ($urandom_range(0, 149) == 0) begin
                async_reset("rnd_rst");
            end else begin
                model_grant();
                av = model_avail();
                s_dv = NR'($urandom) & av;
                s_fl = ($urandom_range(0, 29) == 0);
                for (int i = 0; i < NR; i++) begin
                    s_tag[i]  = TW'($urandom);
                    s_data[i] = $urandom;
                end
                run_cycle("rnd");
            end
        end

        fu_done_valid = '0;
        flush = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the NUM_CDB common data bus ports among NUM_REQ functional units that are finishing.
- Each FU has a one-entry result holding register. Held results compete under rotating priority for CDB ports.
- Per-FU availability is produced as fu_avail. It feeds the FU-availability input of the issue stage, so a stalled FU is never issued into.
- Sits between the EX-stage FU outputs and the CDB/writeback consumers (RS wakeup, ROB, regfile).

Parameters:
NUM_REQ, 8, number of FU result requesters (all categories flattened: ALU, MULT, BRANCH, MEM order)
NUM_CDB, 2, number of CDB broadcast ports
TAG_W, 6, physical register tag width
DATA_W, 32, result data width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
flush  in  1  mispredict squash, synchronous, active-high
fu_done_valid  in  NUM_REQ  FU i presents a completed result this cycle
fu_done_tag  in  NUM_REQ x TAG_W  destination physical tag per FU
fu_done_data  in  NUM_REQ x DATA_W  result value per FU
fu_avail  out  NUM_REQ  FU i may present or issue a result next cycle
cdb_valid  out  NUM_CDB  CDB port k carries a valid broadcast
cdb_tag  out  NUM_CDB x TAG_W  broadcast tag
cdb_data  out  NUM_CDB x DATA_W  broadcast data
cdb_src  out  NUM_CDB x $clog2(NUM_REQ)  index of the granted FU

Behaviour:
- State:
  - held_valid[NUM_REQ], held_tag, held_data (per FU)
  - rr_ptr ($clog2(NUM_REQ) bits)
- Reset (reset_n low, asynchronous):
  - held_valid = 0, rr_ptr = 0
  - Therefore cdb_valid = 0, cdb_tag/data/src = 0, fu_avail = all 1
- Grant (combinational, each cycle):
  - Scan held_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first NUM_CDB set entries are granted, in scan order, to ports 0..NUM_CDB-1.
  - Unused ports: cdb_valid = 0, tag/data/src = 0.
- Latency:
  - fu_done_valid at edge t is captured into held at t.
  - The result can appear on the CDB in cycle t+1 at the earliest. There is no bypass from fu_done to the CDB.
- fu_avail[i] = !held_valid[i] | granted[i] (combinational, same cycle as the grant).
- Capture at each rising edge, for FU i:
  - If fu_done_valid[i] & fu_avail[i]: held <= new result, held_valid <= 1. This is a simultaneous drain-and-refill.
  - Else if granted[i]: held_valid <= 0.
  - Else: hold.
- Protocol rule: fu_done_valid[i] while fu_avail[i] = 0 is illegal. The block ignores the input; the bench asserts on it.
- rr_ptr update:
  - If any grant: rr_ptr <= (index of last granted FU + 1) mod NUM_REQ.
  - Else: unchanged.
- Fairness: a held entry is broadcast within ceil(NUM_REQ/NUM_CDB) cycles of capture.
- Flush (synchronous, sampled at edge):
  - held_valid <= 0 and rr_ptr <= 0. fu_done_valid in the flush cycle is discarded.
  - CDB outputs in the flush cycle still reflect the current grants. Consumers gate them with flush.
- reset_n deassertion mid-traffic: the first edge after release behaves as the empty state.
- All grants are one-hot per FU. No FU is granted to two ports; no port carries two FUs.

Decomposition:
- Shared package:
  - CDB_PACKET typedef {valid, tag, data, src}
  - NUM_CDB constant
  - FU flattening offsets: FU_ALU_BASE, FU_MULT_BASE, FU_BRANCH_BASE, FU_MEM_BASE
- Sub-module rr_multi_select (combinational), parameterised on NUM_REQ and NUM_CDB.
  - Inputs: req vector, start pointer.
  - Outputs: per-port one-hot grant and index, plus last-granted index.
- cdb_arbiter instantiates one rr_multi_select and the holding registers.

Test Plan (NUM_REQ=4, NUM_CDB=2):
1. Reset mid-operation:
   - Stimulus: held = 4'b1011, assert reset_n=0 asynchronously.
   - Required: cdb_valid = 00 and fu_avail = 1111 immediately, before the next edge.
2. Single result:
   - Stimulus: fu_done_valid = 0100, tag 0x05, data 0xDEAD at edge 0.
   - Cycle 1: cdb_valid = 01, cdb_tag[0] = 0x05, cdb_src[0] = 2, fu_avail = 1111.
   - Then rr_ptr = 3.
3. Oversubscription with rr_ptr = 0:
   - Stimulus: all 4 FUs done at edge 0.
   - Cycle 1: ports grant FU0 and FU1; fu_avail = 0011.
   - Cycle 2: grant FU2 and FU3.
   - Cycle 3: cdb_valid = 00.
4. Wraparound:
   - Stimulus: rr_ptr = 3, held = 1001.
   - Required: port0 = FU3, port1 = FU0; rr_ptr becomes 1.
5. Drain-and-refill:
   - Stimulus: FU1 held and granted while fu_done_valid[1] = 1 with tag 0x09.
   - Next cycle: FU1 held_valid = 1 with tag 0x09; no bubble, no loss.
6. Flush:
   - Stimulus: held = 1111 and fu_done_valid = 0001 at a flush edge.
   - Next cycle: held = 0000, cdb_valid = 00, rr_ptr = 0.
   - Protocol-violation assertion never fires under legal stimulus.
